cordic_sin_seq: RTL and testbench

- Sequencer for the shared single-step float32 CORDIC rotation stage (one combinational micro-rotation: x/y shift-add/sub, z ± arctan).
- Loads initial vector x=K, y=0, z=angle, then drives the stage for ITERS iterations: presents the iteration index and arctan(2^-i) constant, waits for the float adders to settle, and registers x1/y1/z1 back as the next inputs.
- Returns sin/cos of the angle with a start/done handshake.
- Sits between the top-level sin calculator and the stage instance.

---
 rtl/cordic_sin_seq_if.sv | 26 ++
 rtl/cordic_sin_seq.sv | 138 +++++++++++++
 tb/tb_cordic_sin_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sin_seq_if.sv
// Host handshake plus stage bus of the CORDIC sin sequencer.
// master: the host and stage side; slave: the sequencer.
interface cordic_sin_seq_if;
  logic        start;
  logic [31:0] angle;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] sin_out;
  logic [31:0] cos_out;
  logic [31:0] stg_x0, stg_y0, stg_z0;
  logic [4:0]  stg_i;
  logic [31:0] stg_arctan;
  logic [31:0] stg_x1, stg_y1, stg_z1;

  modport master (
    output start, angle, stg_x1, stg_y1, stg_z1,
    input  busy, done, err, sin_out, cos_out,
           stg_x0, stg_y0, stg_z0, stg_i, stg_arctan
  );
  modport slave (
    input  start, angle, stg_x1, stg_y1, stg_z1,
    output busy, done, err, sin_out, cos_out,
           stg_x0, stg_y0, stg_z0, stg_i, stg_arctan
  );
endinterface

// File: rtl/cordic_sin_seq.sv
// Drives a shared combinational float32 CORDIC micro-rotation stage for ITERS
// steps and returns sin/cos of the captured angle with a start/done handshake.
module cordic_sin_seq #(
  parameter int          ITERS         = 24,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] K_INIT        = 32'h3F1B74EE
) (
  input logic            clk,
  input logic            rst_n,
  cordic_sin_seq_if.slave sif
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  // With no settle time the stage is captured straight after load/capture
  localparam logic [2:0] S_STEP    = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
  localparam logic [30:0] HALF_PI_MAG = 31'h3FC90FDB;

  logic [2:0]  state;
  logic [4:0]  iter;
  logic [3:0]  settle_cnt;
  logic        busy, done, err;
  logic [31:0] sin_q, cos_q, x0_q, y0_q, z0_q;
  logic [31:0] arctan;
  logic        out_of_range, last_iter, settle_end;

  // Magnitude compare on the raw bits also routes NaN/Inf to the error path
  assign out_of_range = sif.angle[30:0] > HALF_PI_MAG;
  assign last_iter    = iter == 5'(ITERS - 1);
  assign settle_end   = settle_cnt == 4'(SETTLE_CYCLES - 1);

  always_comb begin
    arctan = 32'h0;
    case (iter)
      5'd0:    arctan = 32'h3F490FDB;
      5'd1:    arctan = 32'h3EED6338;
      5'd2:    arctan = 32'h3E7ADBB0;
      5'd3:    arctan = 32'h3DFEADD5;
      5'd4:    arctan = 32'h3D7FAADE;
      5'd5:    arctan = 32'h3CFFEAAE;
      5'd6:    arctan = 32'h3C7FFAAB;
      5'd7:    arctan = 32'h3BFFFEAB;
      5'd8:    arctan = 32'h3B7FFFAB;
      5'd9:    arctan = 32'h3AFFFFEB;
      5'd10:   arctan = 32'h3A7FFFFB;
      5'd11:   arctan = 32'h39FFFFFF;
      5'd12:   arctan = 32'h39800000;
      5'd13:   arctan = 32'h39000000;
      5'd14:   arctan = 32'h38800000;
      5'd15:   arctan = 32'h38000000;
      5'd16:   arctan = 32'h37800000;
      5'd17:   arctan = 32'h37000000;
      5'd18:   arctan = 32'h36800000;
      5'd19:   arctan = 32'h36000000;
      5'd20:   arctan = 32'h35800000;
      5'd21:   arctan = 32'h35000000;
      5'd22:   arctan = 32'h34800000;
      5'd23:   arctan = 32'h34000000;
      default: arctan = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      iter       <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      z0_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (sif.start) begin
            if (out_of_range) begin
              err   <= 1'b1;
              sin_q <= '0;
              cos_q <= '0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err        <= 1'b0;
              busy       <= 1'b1;
              x0_q       <= K_INIT;
              y0_q       <= '0;
              z0_q       <= sif.angle;
              iter       <= '0;
              settle_cnt <= '0;
              state      <= S_LOAD;
            end
          end
        end
        S_LOAD: state <= S_STEP;
        S_SETTLE: begin
          if (settle_end) state <= S_CAPTURE;
          else            settle_cnt <= settle_cnt + 4'd1;
        end
        S_CAPTURE: begin
          x0_q <= sif.stg_x1;
          y0_q <= sif.stg_y1;
          z0_q <= sif.stg_z1;
          if (last_iter) begin
            cos_q <= sif.stg_x1;
            sin_q <= sif.stg_y1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            iter       <= iter + 5'd1;
            settle_cnt <= '0;
            state      <= S_STEP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sif.busy       = busy;
  assign sif.done       = done;
  assign sif.err        = err;
  assign sif.sin_out    = sin_q;
  assign sif.cos_out    = cos_q;
  assign sif.stg_x0     = x0_q;
  assign sif.stg_y0     = y0_q;
  assign sif.stg_z0     = z0_q;
  assign sif.stg_i      = iter;
  assign sif.stg_arctan = arctan;
endmodule

// File: tb/tb_cordic_sin_seq.sv
// Scoreboard bench: default sequencer plus an ITERS=4/SETTLE=0 instance, each
// driving a real-valued float32 micro-rotation stage model.
module tb_cordic_sin_seq;
  localparam logic [31:0] K    = 32'h3F1B74EE;
  localparam logic [31:0] PI6  = 32'h3F060A92;
  localparam logic [31:0] NPI4 = 32'hBF490FDB;
  localparam logic [31:0] PI   = 32'h40490FDB;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] HPI  = 32'h3FC90FDB;
  localparam int  LAT_A = 2 + 24 * 3 - 1;  // acceptance edge to done edge
  localparam int  LAT_B = 2 + 4 * 1 - 1;
  localparam real TOL   = 2.0e-5;

  typedef struct {
    int          t_acc;
    int          lat;
    bit          er;
    logic [31:0] ang;
    real         s_exp;
    real         c_exp;
    logic [31:0] s_bits;
    logic [31:0] c_bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [31:0] rom_tab [0:23] = '{
    32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5, 32'h3D7FAADE, 32'h3CFFEAAE,
    32'h3C7FFAAB, 32'h3BFFFEAB, 32'h3B7FFFAB, 32'h3AFFFFEB, 32'h3A7FFFFB, 32'h39FFFFFF,
    32'h39800000, 32'h39000000, 32'h38800000, 32'h38000000, 32'h37800000, 32'h37000000,
    32'h36800000, 32'h36000000, 32'h35800000, 32'h35000000, 32'h34800000, 32'h34000000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_sin_seq_if a_if ();
  cordic_sin_seq_if b_if ();
  cordic_sin_seq dut (.clk(clk), .rst_n(rst_n), .sif(a_if));
  cordic_sin_seq #(.ITERS(4), .SETTLE_CYCLES(0)) dut4 (.clk(clk), .rst_n(rst_n), .sif(b_if));

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  a;
    int   e;
    int   mant;
    logic s;
    if (r == 0.0) return 32'h0;
    s = r < 0.0;
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    mant = $rtoi((a - 1.0) * 8388608.0 + 0.5);
    if (mant == 8388608) begin mant = 0; e++; end
    if (e < -126) return 32'h0;
    return {s, 8'(e + 127), mant[22:0]};
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // One micro-rotation; direction from the sign of z0
  function automatic logic [95:0] stage_step(input logic [31:0] x0, input logic [31:0] y0,
                                             input logic [31:0] z0, input int i,
                                             input logic [31:0] at);
    real x, y, z, a, s;
    x = f2r(x0); y = f2r(y0); z = f2r(z0); a = f2r(at); s = 1.0;
    for (int k = 0; k < i; k++) s = s / 2.0;
    if (z0[31]) return {r2f(x + y * s), r2f(y - x * s), r2f(z + a)};
    return {r2f(x - y * s), r2f(y + x * s), r2f(z - a)};
  endfunction

  function automatic logic [63:0] ref4(input logic [31:0] ang);
    logic [95:0] v;
    v = {K, 32'h0, ang};
    for (int i = 0; i < 4; i++) v = stage_step(v[95:64], v[63:32], v[31:0], i, rom_tab[i]);
    return v[95:32];
  endfunction

  always_comb {a_if.stg_x1, a_if.stg_y1, a_if.stg_z1} =
    stage_step(a_if.stg_x0, a_if.stg_y0, a_if.stg_z0, int'(a_if.stg_i), a_if.stg_arctan);
  always_comb {b_if.stg_x1, b_if.stg_y1, b_if.stg_z1} =
    stage_step(b_if.stg_x0, b_if.stg_y0, b_if.stg_z0, int'(b_if.stg_i), b_if.stg_arctan);

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor for the default instance ----------------
  exp_t        ea;
  int          busy_a = 0;
  int          rom_bad = 0;
  bit          prev_a = 1'b0;
  logic [31:0] ld_x, ld_y, ld_z, ld_at;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy_a = 0; rom_bad = 0; prev_a = 1'b0;
    end else begin
      if (a_if.busy) begin
        if (!prev_a) begin
          ld_x = a_if.stg_x0; ld_y = a_if.stg_y0; ld_z = a_if.stg_z0; ld_at = a_if.stg_arctan;
        end
        busy_a++;
        if (a_if.stg_i > 5'd23 || a_if.stg_arctan !== rom_tab[a_if.stg_i]) rom_bad++;
      end
      prev_a = a_if.busy;
      if (a_if.done) begin
        if (q_a.size() == 0) chk("a_unexpected_done", 1'b0, 32'(cyc), 32'h0);
        else begin
          ea = q_a.pop_front();
          chk("a_latency", (cyc - ea.t_acc) == ea.lat, 32'(cyc - ea.t_acc), 32'(ea.lat));
          chk("a_err", a_if.err == ea.er, 32'(a_if.err), 32'(ea.er));
          if (ea.er) begin
            chk("a_err_sin", a_if.sin_out == 32'h0, a_if.sin_out, 32'h0);
            chk("a_err_cos", a_if.cos_out == 32'h0, a_if.cos_out, 32'h0);
            chk("a_err_nobusy", busy_a == 0, 32'(busy_a), 32'h0);
          end else begin
            chk("a_sin", rabs(f2r(a_if.sin_out) - ea.s_exp) < TOL, a_if.sin_out, r2f(ea.s_exp));
            chk("a_cos", rabs(f2r(a_if.cos_out) - ea.c_exp) < TOL, a_if.cos_out, r2f(ea.c_exp));
            chk("a_busy_cycles", busy_a == ea.lat, 32'(busy_a), 32'(ea.lat));
            chk("a_load_x", ld_x == K, ld_x, K);
            chk("a_load_y", ld_y == 32'h0, ld_y, 32'h0);
            chk("a_load_z", ld_z == ea.ang, ld_z, ea.ang);
            chk("a_arctan0", ld_at == 32'h3F490FDB, ld_at, 32'h3F490FDB);
            chk("a_rom", rom_bad == 0, 32'(rom_bad), 32'h0);
          end
        end
        busy_a = 0; rom_bad = 0;
      end
    end
  end

  // ---------------- monitor for the ITERS=4 instance ----------------
  exp_t        eb;
  int          busy_b = 0;
  logic [24:0] seq_b = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy_b = 0; seq_b = '0;
    end else begin
      if (b_if.busy) begin
        busy_b++;
        seq_b = {seq_b[19:0], b_if.stg_i};
      end
      if (b_if.done) begin
        if (q_b.size() == 0) chk("b_unexpected_done", 1'b0, 32'(cyc), 32'h0);
        else begin
          eb = q_b.pop_front();
          chk("b_latency", (cyc - eb.t_acc) == eb.lat, 32'(cyc - eb.t_acc), 32'(eb.lat));
          chk("b_err", b_if.err == eb.er, 32'(b_if.err), 32'(eb.er));
          chk("b_sin", b_if.sin_out == eb.s_bits, b_if.sin_out, eb.s_bits);
          chk("b_cos", b_if.cos_out == eb.c_bits, b_if.cos_out, eb.c_bits);
          if (eb.er) chk("b_err_nobusy", busy_b == 0, 32'(busy_b), 32'h0);
          else begin
            chk("b_busy_cycles", busy_b == eb.lat, 32'(busy_b), 32'(eb.lat));
            chk("b_stg_i_seq", seq_b == {5'd0, 5'd0, 5'd1, 5'd2, 5'd3}, 32'(seq_b),
                32'({5'd0, 5'd0, 5'd1, 5'd2, 5'd3}));
          end
        end
        busy_b = 0; seq_b = '0;
      end
    end
  end

  // Called at the negedge before the acceptance edge
  task automatic push_a(input logic [31:0] ang, input bit er, input real s, input real c);
    exp_t e;
    e.t_acc = cyc + 1; e.lat = er ? 0 : LAT_A; e.er = er; e.ang = ang;
    e.s_exp = s; e.c_exp = c; e.s_bits = 32'h0; e.c_bits = 32'h0;
    q_a.push_back(e);
  endtask

  task automatic go_a(input logic [31:0] ang, input bit er, input real s, input real c);
    @(negedge clk);
    a_if.angle = ang; a_if.start = 1'b1;
    push_a(ang, er, s, c);
    @(negedge clk);
    a_if.start = 1'b0;
  endtask

  task automatic go_b(input logic [31:0] ang, input bit er);
    exp_t        e;
    logic [63:0] r;
    r = ref4(ang);
    @(negedge clk);
    b_if.angle = ang; b_if.start = 1'b1;
    e.t_acc = cyc + 1; e.lat = er ? 0 : LAT_B; e.er = er; e.ang = ang;
    e.s_exp = 0.0; e.c_exp = 0.0;
    e.s_bits = er ? 32'h0 : r[31:0]; e.c_bits = er ? 32'h0 : r[63:32];
    q_b.push_back(e);
    @(negedge clk);
    b_if.start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 300; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, q_a.size() == 0 && q_b.size() == 0, 32'(q_a.size() + q_b.size()), 32'h0);
  endtask

  task automatic wait_done_a(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_if.done) break;
    end
    chk(nm, a_if.done, 32'(a_if.done), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    a_if.start = 1'b0; a_if.angle = 32'h0;
    b_if.start = 1'b0; b_if.angle = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy_done_err", {a_if.busy, a_if.done, a_if.err} == 3'b000,
        32'({a_if.busy, a_if.done, a_if.err}), 32'h0);
    chk("rst_sin_cos", (a_if.sin_out | a_if.cos_out) == 32'h0, a_if.sin_out | a_if.cos_out, 32'h0);
    chk("rst_stg", (a_if.stg_x0 | a_if.stg_y0 | a_if.stg_z0 | 32'(a_if.stg_i)) == 32'h0,
        a_if.stg_x0 | a_if.stg_y0 | a_if.stg_z0 | 32'(a_if.stg_i), 32'h0);
    #2 rst_n = 1'b1;

    go_a(PI6, 1'b0, 0.5, 0.8660254);                 wait_drain("to_pi6");
    go_a(NPI4, 1'b0, -0.7071068, 0.7071068);         wait_drain("to_npi4");
    go_a(HPI, 1'b0, 1.0, 0.0);                       wait_drain("to_hpi");
    go_a(PI, 1'b1, 0.0, 0.0);                        wait_drain("to_pi");
    go_a(32'h3FC90FDC, 1'b1, 0.0, 0.0);              wait_drain("to_hpi_plus");
    go_a(32'hC0490FDB, 1'b1, 0.0, 0.0);              wait_drain("to_npi");
    go_a(32'h7FC00000, 1'b1, 0.0, 0.0);              wait_drain("to_nan");

    // start held high: ignored while busy (angle wiggles too), re-accepted in DONE
    @(negedge clk);
    a_if.angle = PI6; a_if.start = 1'b1;
    push_a(PI6, 1'b0, 0.5, 0.8660254);
    repeat (10) @(negedge clk);
    a_if.angle = PI;
    wait_done_a("held_done1");
    a_if.angle = NPI4;
    push_a(NPI4, 1'b0, -0.7071068, 0.7071068);
    repeat (5) @(negedge clk);
    a_if.angle = PI;
    wait_done_a("held_done2");
    a_if.start = 1'b0;
    wait_drain("to_held");

    go_b(PI6, 1'b0);                                 wait_drain("to_b_pi6");
    go_b(NPI4, 1'b0);                                wait_drain("to_b_npi4");
    go_b(PI, 1'b1);                                  wait_drain("to_b_pi");

    // reset in the SETTLE window of iteration 5
    go_a(ONE, 1'b0, 0.8414710, 0.5403023);
    for (int k = 0; k < 100; k++) begin
      if (a_if.stg_i == 5'd5) break;
      @(negedge clk);
    end
    chk("mid_iter5", a_if.stg_i == 5'd5 && a_if.busy, 32'(a_if.stg_i), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {a_if.busy, a_if.done, a_if.err} == 3'b000,
        32'({a_if.busy, a_if.done, a_if.err}), 32'h0);
    chk("mid_rst_stg", (a_if.stg_x0 | a_if.stg_y0 | a_if.stg_z0 | 32'(a_if.stg_i)) == 32'h0,
        a_if.stg_x0 | a_if.stg_y0 | a_if.stg_z0 | 32'(a_if.stg_i), 32'h0);
    q_a.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    go_a(ONE, 1'b0, 0.8414710, 0.5403023);           wait_drain("to_after_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
